// File: rtl/ifq_pkg.sv
// Shared types and helpers for the instruction fetch queue: reset PC default,
// queue entry layout and the counter-width rule used by the top and the FIFO.
package ifq_pkg;

  localparam logic [31:0] IFQ_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifq_entry_t;

  // Counters must hold the value DEPTH itself, hence one bit above the index width.
  function automatic int ifq_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Circular prefetch buffer of {pc, instr} entries with push/pop/flush and
// registered head outputs (the head is valid the cycle after the push that fills it).
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  ifq_entry_t                    push_entry,
  input  logic                          pop,
  input  logic                          flush,
  output logic                          head_valid,
  output ifq_entry_t                    head_entry,
  output logic [ifq_cnt_w(DEPTH)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = ifq_cnt_w(DEPTH);

  ifq_entry_t    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          pop_ok;
  logic          push_ok;
  ifq_entry_t    head_nxt;

  assign pop_ok  = pop & head_valid & ~flush;
  assign push_ok = push & ~flush & ((count != CW'(DEPTH)) | pop_ok);

  // A push landing in the slot that becomes the new head forwards its data
  // into the head register; otherwise the head comes from storage.
  always_comb begin
    rd_nxt   = pop_ok ? rd_ptr + AW'(1) : rd_ptr;
    cnt_nxt  = count + CW'(push_ok) - CW'(pop_ok);
    head_nxt = (push_ok && (wr_ptr == rd_nxt)) ? push_entry : mem[rd_nxt];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head_entry <= '0;
    end else if (flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head_entry <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr     <= rd_nxt;
      count      <= cnt_nxt;
      head_valid <= (cnt_nxt != '0);
      head_entry <= (cnt_nxt != '0) ? head_nxt : '0;
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front end: fetch PC, credit-limited in-order imem requests, redirect flush
// with in-flight discard. Optional stall counter port when IFQ_PERF_EN is defined.
module instr_fetch_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = IFQ_RESET_PC
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
`ifdef IFQ_PERF_EN
 ,output logic [31:0] stall_cnt_o
`endif
);

  localparam int            CW      = ifq_cnt_w(DEPTH);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

  logic [CW-1:0] occ;
  logic [CW-1:0] live;
  logic [CW-1:0] drop;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   redirect_tgt;
  logic [CW:0]   occ_live;
  logic [CW:0]   live_drop;
  logic          issue;
  logic          resp_any;
  logic          resp_keep;
  logic          resp_discard;
  ifq_entry_t    push_entry;
  ifq_entry_t    head_entry;

  assign redirect_tgt = {redirect_pc_i[31:2], 2'b00};
  assign occ_live     = {1'b0, occ} + {1'b0, live};
  assign live_drop    = {1'b0, live} + {1'b0, drop};

  // Credit: room in the queue for every kept response, and every outstanding
  // request (kept or discarded) bounded by DEPTH.
  assign imem_req_o   = ~rst_i & ~redirect_i & (occ_live < DEPTH_C) & (live_drop < DEPTH_C);
  assign imem_addr_o  = fetch_pc;
  assign issue        = imem_req_o & imem_ready_i;

  assign resp_any     = imem_rvalid_i & (live_drop != '0);
  assign resp_discard = imem_rvalid_i & ~redirect_i & (drop != '0);
  assign resp_keep    = imem_rvalid_i & ~redirect_i & (drop == '0) & (live != '0);

  assign push_entry   = '{pc: resp_pc, instr: imem_rdata_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      live     <= '0;
      drop     <= '0;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
    end else if (redirect_i) begin
      // Everything still in flight becomes garbage; a response arriving now is one of them.
      live     <= '0;
      drop     <= drop + live - CW'(resp_any);
      fetch_pc <= redirect_tgt;
      resp_pc  <= redirect_tgt;
    end else begin
      live     <= live + CW'(issue) - CW'(resp_keep);
      drop     <= drop - CW'(resp_discard);
      if (issue)     fetch_pc <= fetch_pc + 32'd4;
      if (resp_keep) resp_pc  <= resp_pc + 32'd4;
    end
  end

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk_i),
    .rst        (rst_i),
    .push       (resp_keep),
    .push_entry (push_entry),
    .pop        (instr_ready_i & ~redirect_i),
    .flush      (redirect_i),
    .head_valid (instr_valid_o),
    .head_entry (head_entry),
    .count      (occ)
  );

  assign instr_o    = head_entry.instr;
  assign instr_pc_o = head_entry.pc;

`ifdef IFQ_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)               stall_cnt_o <= '0;
    else if (!instr_valid_o) stall_cnt_o <= sat_inc(stall_cnt_o);
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: streaming, back-pressure, redirects,
// PC wrap and mid-burst reset against a latency-configurable memory stub.
module tb_instr_fetch_queue;
  import ifq_pkg::*;

  localparam logic [31:0] MAGIC = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i = 1'b0;
`ifdef IFQ_PERF_EN
  logic [31:0] stall_cnt_o;
`endif

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ready_i  (imem_ready_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i)
`ifdef IFQ_PERF_EN
   ,.stall_cnt_o   (stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] addr; } pend_t;
  pend_t       pend[$];
  logic [31:0] iss_log[$];
  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int lat  = 1;

  // Memory stub: request issued in cycle c answers in cycle c+lat with addr^MAGIC.
  task automatic tick();
    logic iss, rv;
    logic [31:0] a;
    #1;
    iss = imem_req_o & imem_ready_i;
    a   = imem_addr_o;
    rv  = imem_rvalid_i;
    @(posedge clk);
    if (rv && pend.size() > 0) void'(pend.pop_front());
    if (iss) begin
      pend.push_back('{cyc + lat, a});
      iss_log.push_back(a);
    end
    cyc++;
    #1;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = pend[0].addr ^ MAGIC;
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
    end
  endtask

  task automatic do_reset();
    #1 rst_i = 1'b1;
    redirect_i = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i = '0;
    pend.delete();
    iss_log.delete();
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    cyc = 0;
    #1;
  endtask

  task automatic test_reset();
    #1 rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nvec++; if (imem_req_o !== 1'b0) begin nerr++; $display("FAIL rst_req got %b want 0", imem_req_o); end
    nvec++; if (imem_addr_o !== 32'h0) begin nerr++; $display("FAIL rst_addr got %h want 00000000", imem_addr_o); end
    nvec++; if (instr_valid_o !== 1'b0) begin nerr++; $display("FAIL rst_valid got %b want 0", instr_valid_o); end
    nvec++; if (instr_o !== 32'h0) begin nerr++; $display("FAIL rst_instr got %h want 00000000", instr_o); end
    nvec++; if (instr_pc_o !== 32'h0) begin nerr++; $display("FAIL rst_pc got %h want 00000000", instr_pc_o); end
    rst_i = 1'b0;
    cyc = 0;
    #1;
    nvec++; if (imem_req_o !== 1'b1) begin nerr++; $display("FAIL first_req got %b want 1", imem_req_o); end
    nvec++; if (imem_addr_o !== 32'h0) begin nerr++; $display("FAIL first_addr got %h want 00000000", imem_addr_o); end
  endtask

  task automatic test_stream();
    do_reset();
    lat = 1; imem_ready_i = 1'b1; instr_ready_i = 1'b1;
    tick();
    nvec++; if (instr_valid_o !== 1'b0) begin nerr++; $display("FAIL stream_c1_valid got %b want 0", instr_valid_o); end
    tick();
    for (int k = 0; k < 6; k++) begin
      nvec++; if (instr_valid_o !== 1'b1) begin nerr++; $display("FAIL stream_valid[%0d] got %b want 1", k, instr_valid_o); end
      nvec++; if (instr_pc_o !== 32'(4 * k)) begin nerr++; $display("FAIL stream_pc[%0d] got %h want %h", k, instr_pc_o, 32'(4 * k)); end
      nvec++; if (instr_o !== (32'(4 * k) ^ MAGIC)) begin nerr++; $display("FAIL stream_instr[%0d] got %h want %h", k, instr_o, 32'(4 * k) ^ MAGIC); end
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      nvec++; if (iss_log[i] !== 32'(4 * i)) begin nerr++; $display("FAIL stream_addr[%0d] got %h want %h", i, iss_log[i], 32'(4 * i)); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    lat = 1; imem_ready_i = 1'b1; instr_ready_i = 1'b0;
    repeat (8) tick();
    nvec++; if (iss_log.size() !== 4) begin nerr++; $display("FAIL bp_issued got %0d want 4", iss_log.size()); end
    nvec++; if (imem_req_o !== 1'b0) begin nerr++; $display("FAIL bp_req_full got %b want 0", imem_req_o); end
    nvec++; if (instr_pc_o !== 32'h0) begin nerr++; $display("FAIL bp_head got %h want 00000000", instr_pc_o); end
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    #1;
    nvec++; if (imem_req_o !== 1'b1) begin nerr++; $display("FAIL bp_req_after_pop got %b want 1", imem_req_o); end
    nvec++; if (imem_addr_o !== 32'h10) begin nerr++; $display("FAIL bp_addr_after_pop got %h want 00000010", imem_addr_o); end
    nvec++; if (instr_pc_o !== 32'h4) begin nerr++; $display("FAIL bp_head_after_pop got %h want 00000004", instr_pc_o); end
    tick();
    nvec++; if (imem_req_o !== 1'b0) begin nerr++; $display("FAIL bp_req_refull got %b want 0", imem_req_o); end
    nvec++; if (iss_log.size() !== 5) begin nerr++; $display("FAIL bp_issued2 got %0d want 5", iss_log.size()); end
  endtask

  task automatic test_redirect_inflight();
    bit found;
    do_reset();
    lat = 3; imem_ready_i = 1'b1; instr_ready_i = 1'b1;
    repeat (2) tick();
    imem_ready_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0102;
    #1;
    nvec++; if (imem_req_o !== 1'b0) begin nerr++; $display("FAIL redir_req got %b want 0", imem_req_o); end
    tick();
    redirect_i = 1'b0; imem_ready_i = 1'b1;
    #1;
    nvec++; if (imem_req_o !== 1'b1) begin nerr++; $display("FAIL redir_next_req got %b want 1", imem_req_o); end
    nvec++; if (imem_addr_o !== 32'h100) begin nerr++; $display("FAIL redir_next_addr got %h want 00000100", imem_addr_o); end
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (instr_valid_o) found = 1'b1;
    end
    nvec++; if (!found) begin nerr++; $display("FAIL redir_timeout got no valid want valid within 12 cycles"); end
    nvec++; if (cyc !== 7) begin nerr++; $display("FAIL redir_first_cycle got %0d want 7", cyc); end
    nvec++; if (instr_pc_o !== 32'h100) begin nerr++; $display("FAIL redir_first_pc got %h want 00000100", instr_pc_o); end
    nvec++; if (instr_o !== (32'h100 ^ MAGIC)) begin nerr++; $display("FAIL redir_first_instr got %h want %h", instr_o, 32'h100 ^ MAGIC); end
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    lat = 1; imem_ready_i = 1'b1; instr_ready_i = 1'b0;
    repeat (2) tick();
    imem_ready_i = 1'b0; instr_ready_i = 1'b1;
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
    #1;
    nvec++; if (instr_valid_o !== 1'b1) begin nerr++; $display("FAIL same_pre_valid got %b want 1", instr_valid_o); end
    tick();
    redirect_i = 1'b0;
    #1;
    nvec++; if (instr_valid_o !== 1'b0) begin nerr++; $display("FAIL same_flush_valid got %b want 0", instr_valid_o); end
    nvec++; if (imem_req_o !== 1'b1) begin nerr++; $display("FAIL same_req got %b want 1", imem_req_o); end
    nvec++; if (imem_addr_o !== 32'h200) begin nerr++; $display("FAIL same_addr got %h want 00000200", imem_addr_o); end
    tick();
    nvec++; if (instr_valid_o !== 1'b0) begin nerr++; $display("FAIL same_spurious got %b want 0", instr_valid_o); end
  endtask

  task automatic test_wrap();
    do_reset();
    lat = 1; imem_ready_i = 1'b1; instr_ready_i = 1'b1;
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    #1;
    nvec++; if (imem_addr_o !== 32'hFFFF_FFFC) begin nerr++; $display("FAIL wrap_addr0 got %h want fffffffc", imem_addr_o); end
    tick();
    nvec++; if (imem_addr_o !== 32'h0) begin nerr++; $display("FAIL wrap_addr1 got %h want 00000000", imem_addr_o); end
    tick();
    nvec++; if (instr_pc_o !== 32'hFFFF_FFFC) begin nerr++; $display("FAIL wrap_pc0 got %h want fffffffc", instr_pc_o); end
    tick();
    nvec++; if (instr_pc_o !== 32'h0) begin nerr++; $display("FAIL wrap_pc1 got %h want 00000000", instr_pc_o); end
  endtask

  task automatic test_reset_midburst();
    do_reset();
    lat = 1; imem_ready_i = 1'b1; instr_ready_i = 1'b0;
    repeat (4) tick();
    nvec++; if (instr_valid_o !== 1'b1) begin nerr++; $display("FAIL mid_pre_valid got %b want 1", instr_valid_o); end
    rst_i = 1'b1;
    #1;
    nvec++; if (instr_valid_o !== 1'b0) begin nerr++; $display("FAIL mid_valid got %b want 0", instr_valid_o); end
    nvec++; if (instr_pc_o !== 32'h0) begin nerr++; $display("FAIL mid_pc got %h want 00000000", instr_pc_o); end
    nvec++; if (instr_o !== 32'h0) begin nerr++; $display("FAIL mid_instr got %h want 00000000", instr_o); end
    nvec++; if (imem_req_o !== 1'b0) begin nerr++; $display("FAIL mid_req got %b want 0", imem_req_o); end
    nvec++; if (imem_addr_o !== 32'h0) begin nerr++; $display("FAIL mid_addr got %h want 00000000", imem_addr_o); end
`ifdef IFQ_PERF_EN
    nvec++; if (stall_cnt_o !== 32'd0) begin nerr++; $display("FAIL mid_stall got %0d want 0", stall_cnt_o); end
`endif
    @(posedge clk);
    #1;
    rst_i = 1'b0; cyc = 0;
    pend.delete(); iss_log.delete();
    imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    #1;
    nvec++; if (imem_req_o !== 1'b1) begin nerr++; $display("FAIL mid_restart_req got %b want 1", imem_req_o); end
    nvec++; if (imem_addr_o !== 32'h0) begin nerr++; $display("FAIL mid_restart_addr got %h want 00000000", imem_addr_o); end
    tick();
`ifdef IFQ_PERF_EN
    nvec++; if (stall_cnt_o !== 32'd1) begin nerr++; $display("FAIL stall_c1 got %0d want 1", stall_cnt_o); end
`endif
    tick();
    nvec++; if (instr_valid_o !== 1'b1) begin nerr++; $display("FAIL mid_restart_valid got %b want 1", instr_valid_o); end
    nvec++; if (instr_pc_o !== 32'h0) begin nerr++; $display("FAIL mid_restart_pc got %h want 00000000", instr_pc_o); end
    tick();
`ifdef IFQ_PERF_EN
    nvec++; if (stall_cnt_o !== 32'd2) begin nerr++; $display("FAIL stall_c3 got %0d want 2", stall_cnt_o); end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_same_cycle();
    test_wrap();
    test_reset_midburst();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
